// File: rtl/regfile_access_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_access_ctrl_pkg
// Description : Shared widths, read-FSM state encoding and helpers for the
//               register-file access controller.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_access_ctrl_pkg;

    localparam int REG_AW = 5;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } rd_state_t;

    // A write to register 0 is discarded when dropping is enabled.
    function automatic logic drop_write(input logic drop_r0, input logic [REG_AW-1:0] reg_addr);
        return drop_r0 && (reg_addr == '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_wb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_fifo
// Description : Synchronous FIFO buffering writeback requests {reg, data}.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 37
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign full      = (r_count == (PW+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign head_data = r_mem[r_rd_ptr];
    assign w_push    = push && !full;
    assign w_pop     = pop && !empty;

    // Storage carries no reset; only pointers and occupancy define validity.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= PW'(r_wr_ptr + 1'b1);
            end
            if (w_pop) begin
                r_rd_ptr <= PW'(r_rd_ptr + 1'b1);
            end
            if (w_push && !w_pop) begin
                r_count <= (PW+1)'(r_count + 1'b1);
            end else if (!w_push && w_pop) begin
                r_count <= (PW+1)'(r_count - 1'b1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : regfile_access_ctrl
// Description : Register-file initiator: buffered writebacks, one outstanding
//               read with a backpressured response, read-after-write ordering.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_access_ctrl
    import regfile_access_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int DROP_R0    = 1
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           wb_valid,
    output logic                           wb_ready,
    input  logic [REG_AW-1:0]              wb_reg,
    input  logic [DATA_W-1:0]              wb_data,
    input  logic                           rd_valid,
    output logic                           rd_ready,
    input  logic [REG_AW-1:0]              rd_rr1,
    input  logic [REG_AW-1:0]              rd_rr2,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [DATA_W-1:0]              rsp_data1,
    output logic [DATA_W-1:0]              rsp_data2,
    output logic                           rf_regwrite,
    output logic [REG_AW-1:0]              rf_wr,
    output logic [DATA_W-1:0]              rf_write_data,
    output logic [REG_AW-1:0]              rf_rr1,
    output logic [REG_AW-1:0]              rf_rr2,
    input  logic [DATA_W-1:0]              rf_rdata1,
    input  logic [DATA_W-1:0]              rf_rdata2,
    output logic [$clog2(FIFO_DEPTH):0]    wb_count
);

    localparam int WB_W = REG_AW + DATA_W;

    rd_state_t          r_state;
    rd_state_t          w_next;
    logic               w_full;
    logic               w_empty;
    logic [WB_W-1:0]    w_head;
    logic               w_push;
    logic               w_issue;
    logic               w_rd_ready;
    logic [REG_AW-1:0]  r_rr1;
    logic [REG_AW-1:0]  r_rr2;
    logic [DATA_W-1:0]  r_rsp_data1;
    logic [DATA_W-1:0]  r_rsp_data2;

    // A waiting read blocks new writes so the FIFO can drain ahead of it.
    assign wb_ready = !w_full && !rd_valid;
    assign w_push   = wb_valid && wb_ready && !drop_write(DROP_R0 != 0, wb_reg);

    regfile_wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WB_W)
    ) u_wb_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (w_push),
        .push_data ({wb_reg, wb_data}),
        .pop       (!w_empty),
        .head_data (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .count     (wb_count)
    );

    assign rf_regwrite   = !w_empty;
    assign rf_wr         = w_head[DATA_W +: REG_AW];
    assign rf_write_data = w_head[DATA_W-1:0];

    always_comb begin
        w_next     = r_state;
        w_rd_ready = 1'b0;
        w_issue    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_rd_ready = (wb_count == '0);
                if (rd_valid && w_rd_ready) begin
                    w_issue = 1'b1;
                    w_next  = S_WAIT;
                end
            end
            S_WAIT: begin
                w_next = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign rd_ready  = w_rd_ready;
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_data1 = r_rsp_data1;
    assign rsp_data2 = r_rsp_data2;

    // The issuing cycle presents the new addresses; otherwise the last issued pair is held.
    assign rf_rr1 = w_issue ? rd_rr1 : r_rr1;
    assign rf_rr2 = w_issue ? rd_rr2 : r_rr2;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_rr1       <= '0;
            r_rr2       <= '0;
            r_rsp_data1 <= '0;
            r_rsp_data2 <= '0;
        end else begin
            r_state <= w_next;
            if (w_issue) begin
                r_rr1 <= rd_rr1;
                r_rr2 <= rd_rr2;
            end
            if (r_state == S_WAIT) begin
                r_rsp_data1 <= rf_rdata1;
                r_rsp_data2 <= rf_rdata2;
            end
        end
    end

endmodule
`default_nettype wire
